// File: rtl/hamming_pkg.sv
// Shared Hamming(15,11) types and constants: widths, parity positions, slot FSM states.
package hamming_pkg;
  localparam int DATA_W = 11;
  localparam int CODE_W = 15;
  localparam int P1_IDX = 0;
  localparam int P2_IDX = 1;
  localparam int P4_IDX = 3;
  localparam int P8_IDX = 7;

  typedef logic [0:DATA_W-1] data_t;
  typedef logic [0:CODE_W-1] code_t;
  typedef enum logic {EMPTY, FULL} state_t;
endpackage

// File: rtl/calcula_hamming.sv
// Combinational Hamming(15,11) encoder, even parity; index 0 = codeword position 1.
module calcula_hamming
  import hamming_pkg::*;
(
  input  data_t data,
  output code_t code
);
  always_comb begin
    code         = '0;
    code[P1_IDX] = data[0] ^ data[1] ^ data[3] ^ data[4] ^ data[6] ^ data[8] ^ data[10];
    code[P2_IDX] = data[0] ^ data[2] ^ data[3] ^ data[5] ^ data[6] ^ data[9] ^ data[10];
    code[P4_IDX] = data[1] ^ data[2] ^ data[3] ^ data[7] ^ data[8] ^ data[9] ^ data[10];
    code[P8_IDX] = data[4] ^ data[5] ^ data[6] ^ data[7] ^ data[8] ^ data[9] ^ data[10];
    code[2]      = data[0];
    code[4:6]    = data[1:3];
    code[8:14]   = data[4:10];
  end
endmodule

// File: rtl/rr_arbiter.sv
// Pointer-based round-robin arbiter: combinational one-hot grant, pointer advances past the winner on upd.
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         upd,
  output logic [N-1:0] grant,
  output logic [W-1:0] grant_idx
);
  logic [W-1:0] ptr;
  logic         found;
  int           j;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    j         = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!found && req[j[W-1:0]]) begin
        found              = 1'b1;
        grant[j[W-1:0]]    = 1'b1;
        grant_idx          = j[W-1:0];
      end
    end
  end

  // Explicit wrap so a non-power-of-two N never yields an out-of-range pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (upd) begin
      if (int'(grant_idx) == N - 1) ptr <= '0;
      else                          ptr <= grant_idx + 1'b1;
    end
  end
endmodule

// File: rtl/hamming_enc_arbiter.sv
// Round-robin shares one Hamming(15,11) encoder across NUM_REQ requesters into a 1-deep valid/ready slot (1-cycle latency).
// Macro HAMMING_ENC_ARB_SECDED_EN adds out_pall (overall even parity, SECDED 16,11).
module hamming_enc_arbiter
  import hamming_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int SRC_W   = $clog2(NUM_REQ),
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      out_valid,
  input  logic                      out_ready,
  output code_t                     out_code,
  output logic [SRC_W-1:0]          out_src,
  output logic [CNT_W-1:0]          word_cnt
`ifdef HAMMING_ENC_ARB_SECDED_EN
  , output logic                    out_pall
`endif
);
  localparam int IDX_W = $clog2(NUM_REQ);

  state_t             state;
  logic               load_en;
  logic               hs;
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   gidx;
  data_t              words [NUM_REQ];
  data_t              word;
  code_t              enc;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_word
    for (genvar k = 0; k < DATA_W; k++) begin : g_bit
      assign words[i][k] = req_data[i*DATA_W + k];
    end
  end

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req_valid),
    .upd       (hs),
    .grant     (grant),
    .grant_idx (gidx)
  );

  // rst_n gating keeps req_ready low during reset even though EMPTY would allow a load.
  assign load_en   = (state == EMPTY) || out_ready;
  assign req_ready = grant & {NUM_REQ{load_en & rst_n}};
  assign hs        = |req_ready;
  assign word      = words[gidx];

  calcula_hamming u_enc (
    .data (word),
    .code (enc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      out_code  <= '0;
      out_src   <= '0;
      word_cnt  <= '0;
`ifdef HAMMING_ENC_ARB_SECDED_EN
      out_pall  <= 1'b0;
`endif
    end else begin
      if (hs) begin
        out_code <= enc;
        out_src  <= SRC_W'(gidx);
        word_cnt <= word_cnt + 1'b1;
`ifdef HAMMING_ENC_ARB_SECDED_EN
        out_pall <= ^enc;
`endif
      end
      case (state)
        EMPTY: if (hs) begin
          state     <= FULL;
          out_valid <= 1'b1;
        end
        FULL: if (out_ready && !hs) begin
          state     <= EMPTY;
          out_valid <= 1'b0;
        end
        default: begin
          state     <= EMPTY;
          out_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: doc/hamming_enc_arbiter.md
Name: hamming_enc_arbiter

Overview:
- Shares one Hamming(15,11) encoder among NUM_REQ requesters. Each requester offers an 11-bit data word.
- Grants one requester per cycle, round-robin. Encodes the granted word and registers it into a single output slot with valid/ready handshake, tagged with the source index.
- Sits between the data producers and the channel/serialiser that consumes 15-bit codewords.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..16.
- SRC_W, $clog2(NUM_REQ), width of source tag.
- CNT_W, 16, width of accepted-word counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NUM_REQ  per-requester word-available flag.
- req_data  input  NUM_REQ*11  packed data words; requester i occupies bits [i*11 +: 11]. Within a word, index 0 = D1 … index 10 = D11.
- req_ready  output  NUM_REQ  per-requester accept; one-hot or zero.
- out_valid  output  1  codeword slot full.
- out_ready  input  1  consumer accepts codeword.
- out_code  output  15  codeword, index 0 = position 1 … index 14 = position 15. Parity P1, P2, P4, P8 at indices 0, 1, 3, 7; D1..D11 at 2, 4, 5, 6, 8..14.
- out_src  output  SRC_W  requester index that produced out_code.
- word_cnt  output  CNT_W  count of accepted words, wraps.

Behaviour:
- Reset (async assert, sync-style release on next clk):
  - out_valid=0, out_code=0, out_src=0, word_cnt=0.
  - rr_ptr=0, FSM=EMPTY.
  - req_ready=0 while rst_n=0.
- FSM states:
  - EMPTY: slot empty. load_en=1.
  - FULL: slot holds a codeword. load_en=out_ready.
  - Transitions: EMPTY→FULL on grant. FULL→EMPTY when out_ready and no grant. FULL→FULL when out_ready and grant (back-to-back). FULL stays FULL when out_ready=0.
- Grant (combinational):
  - Search req_valid starting at rr_ptr, wrapping modulo NUM_REQ; first set bit wins.
  - grant_vec is one-hot or zero.
  - req_ready = grant_vec & {NUM_REQ{load_en}}.
  - req_ready never depends on a requester's own req_valid, apart from via the arbitration result.
- On handshake (any req_ready bit = 1), at the clock edge:
  - out_code <= encode(req_data[g]); out_src <= g; out_valid <= 1.
  - rr_ptr <= (g+1) mod NUM_REQ.
  - word_cnt <= word_cnt+1, wrapping from 2^CNT_W-1 to 0.
- Latency: data is accepted on cycle N and presented on out_code at cycle N+1. Throughput is 1 word/cycle when out_ready is held high.
- Encoding: parity bits are even parity over the standard Hamming cover sets.
  - P1 = D1^D2^D4^D5^D7^D9^D11.
  - P2 = D1^D3^D4^D6^D7^D10^D11.
  - P4 = D2^D3^D4^D8^D9^D10^D11.
  - P8 = D5^D6^D7^D8^D9^D10^D11.
- Output stability: out_code and out_src hold stable while out_valid=1 and out_ready=0.
- Boundary conditions:
  - No requesters valid: no grant; rr_ptr unchanged.
  - Single requester continuously valid: it wins every load cycle.
  - All requesters valid: service order ptr, ptr+1, …; no requester is starved beyond NUM_REQ-1 grants.
  - NUM_REQ not a power of two: rr_ptr wraps from NUM_REQ-1 to 0; out-of-range pointer values never occur.
  - Reset mid-transfer: the codeword in the slot is discarded; no partial handshake is recorded.

Optional Feature:
- Macro: HAMMING_ENC_ARB_SECDED_EN.
- Defined: adds output port out_pall (1 bit), registered alongside out_code. It is the even overall parity (XOR of all 15 codeword bits), giving SECDED (16,11). Reset value 0.
- Undefined: port absent; no extra logic.

Decomposition:
- Shared package hamming_pkg:
  - constants DATA_W=11, CODE_W=15.
  - parity position constants P1_IDX=0, P2_IDX=1, P4_IDX=3, P8_IDX=7.
  - typedefs data_t [0:10] and code_t [0:14].
  - state enum {EMPTY, FULL}.
- Encoder: the block instantiates the team's existing combinational encoder calcula_hamming on the muxed granted word.
- Sub-module: rr_arbiter (parameter N), covering pointer-based round-robin grant, one-hot output and pointer update input.

Test Plan:
1. Reset: hold rst_n=0 with req_valid=4'b1111 → req_ready=0, out_valid=0, word_cnt=0. Release → first grant goes to requester 0.
2. Single word: requester 2 sends 11'b000_0000_0001 (D11=1) with out_ready=1 → one cycle later out_valid=1, out_src=2, out_code=15'b110_1000_1000_0001 (P1=P2=P4=P8=1, D11=1).
3. Fairness: all 4 requesters continuously valid, out_ready=1 for 8 cycles → out_src sequence 0,1,2,3,0,1,2,3; word_cnt=8.
4. Backpressure: out_ready=0 for 5 cycles with the slot full → req_ready=0 and out_code stable. Set out_ready=1 → next word loads the same cycle with no bubble.
5. NUM_REQ=3 with requesters 0 and 2 valid → grants alternate 0,2,0,2; rr_ptr never reaches 3.
6. SECDED (macro defined): data 11'h7FF → out_code=15'h7FFF and out_pall=1. Inject a reset mid-FULL → out_valid=0 immediately.
